sevseg_reader: RTL and testbench

SEVSEG_READER -- requirements
Module: sevseg_reader

---
 rtl/sevseg_pkg.sv | 51 +++++
 rtl/sevseg_sync_stable.sv | 46 ++++
 rtl/sevseg_reader.sv | 98 +++++++++
 tb/tb_sevseg_reader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - seven-segment pattern constants, FSM states and digit decode
package sevseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PRESENT
    } state_t;

    // Returns {err, hex}; anything that is not one of the 16 digits is an error with hex 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        case (pat)
            SEG_0:   return 5'h00;
            SEG_1:   return 5'h01;
            SEG_2:   return 5'h02;
            SEG_3:   return 5'h03;
            SEG_4:   return 5'h04;
            SEG_5:   return 5'h05;
            SEG_6:   return 5'h06;
            SEG_7:   return 5'h07;
            SEG_8:   return 5'h08;
            SEG_9:   return 5'h09;
            SEG_A:   return 5'h0A;
            SEG_B:   return 5'h0B;
            SEG_C:   return 5'h0C;
            SEG_D:   return 5'h0D;
            SEG_E:   return 5'h0E;
            SEG_F:   return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

endpackage

// File: rtl/sevseg_sync_stable.sv
// rtl/sevseg_sync_stable.sv - two-flop synchronizer plus saturating stability counter
module sevseg_sync_stable
    import sevseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_n_i,
    output logic [6:0] sync_pat_o,
    output logic       stable_o
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [6:0] meta_q;
    logic [6:0] sync_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // meta_q differing from sync_q means sync_q changes on this edge.
    always_comb begin
        cnt_d = cnt_q;
        if (meta_q != sync_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= SEG_BLANK;
            sync_q <= SEG_BLANK;
            cnt_q  <= 8'd0;
        end else begin
            meta_q <= seg_n_i;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
        end
    end

    assign sync_pat_o = sync_q;
    assign stable_o   = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sevseg_reader.sv
// rtl/sevseg_reader.sv - reads a seven-segment display and reports each new stable digit
module sevseg_reader
    import sevseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_n,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_hex,
    output logic       out_err,
    output logic [7:0] err_count
);

    state_t     state_q, state_d;
    logic [6:0] last_pat_q, last_pat_d;
    logic [3:0] hex_q, hex_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [6:0] sync_pat;
    logic       stable;
    logic [4:0] dec;

    sevseg_sync_stable #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .seg_n_i    (seg_n),
        .sync_pat_o (sync_pat),
        .stable_o   (stable)
    );

    assign dec = seg_decode(sync_pat);

    always_comb begin
        state_d    = state_q;
        last_pat_d = last_pat_q;
        hex_d      = hex_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sync_pat != last_pat_q) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (sync_pat == last_pat_q) begin
                    state_d = ST_IDLE;
                end else if (stable) begin
                    // A settled blank re-arms the same digit without producing a report.
                    last_pat_d = sync_pat;
                    if (sync_pat == SEG_BLANK) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PRESENT;
                        hex_d   = dec[3:0];
                        err_d   = dec[4];
                    end
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    if (err_q && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_pat_q <= SEG_BLANK;
            hex_q      <= 4'd0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            last_pat_q <= last_pat_d;
            hex_q      <= hex_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = (state_q == ST_PRESENT);
    assign out_hex   = hex_q;
    assign out_err   = err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_sevseg_reader.sv
// tb/tb_sevseg_reader.sv - scoreboard bench for sevseg_reader
module tb_sevseg_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_n = 7'h7F;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] out_hex;
    logic       out_err;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_err_cnt = 0;
    logic [4:0] exp_q[$];

    logic [6:0] digit_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] bad_pat [4] = '{7'h7E, 7'h7D, 7'h01, 7'h55};

    sevseg_reader #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_n     (seg_n),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_hex   (out_hex),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // A report seen valid&ready at the falling edge is transferred on the next rising edge.
    always @(negedge clk) begin
        logic [4:0] e;
        if (reset) begin
            exp_err_cnt = 0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_report", {27'd0, out_err, out_hex}, -1);
            end else begin
                e = exp_q.pop_front();
                check_eq("report_hex", int'(out_hex), int'(e[3:0]));
                check_eq("report_err", int'(out_err), int'(e[4]));
                if (e[4] && exp_err_cnt < 255) exp_err_cnt++;
            end
        end
    end

    task automatic hold(input logic [6:0] pat, input int cycles);
        seg_n = pat;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, int'(out_valid), 1);
    endtask

    initial begin
        #12;
        check_eq("rst_valid", int'(out_valid), 0);
        check_eq("rst_hex", int'(out_hex), 0);
        check_eq("rst_err", int'(out_err), 0);
        check_eq("rst_err_count", int'(err_count), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;

        for (int d = 0; d < 16; d++) begin
            exp_q.push_back({1'b0, 4'(d)});
            hold(digit_pat[d], 10);
            hold(7'h7F, 10);
        end
        drain("digits_drain");
        check_eq("digits_err_count", int'(err_count), 0);

        exp_q.push_back(5'h01);
        hold(7'h79, 40);
        hold(7'h7F, 10);
        exp_q.push_back(5'h01);
        hold(7'h79, 10);
        hold(7'h7F, 10);
        drain("repeat_drain");

        exp_q.push_back(5'h10);
        hold(7'h7E, 10);
        hold(7'h7F, 10);
        drain("illegal_drain");
        check_eq("err_count_one", int'(err_count), exp_err_cnt);
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(5'h10);
            hold(bad_pat[i % 4], 8);
            hold(7'h7F, 8);
        end
        drain("sat_drain");
        check_eq("err_count_sat", int'(err_count), exp_err_cnt);
        check_eq("err_count_255", int'(err_count), 255);

        out_ready = 1'b0;
        exp_q.push_back(5'h03);
        seg_n = 7'h30;
        wait_valid("hold_valid");
        seg_n = 7'h12;
        exp_q.push_back(5'h05);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("hold_hex", int'(out_hex), 3);
            check_eq("hold_valid_high", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("hold_drain");

        exp_q.push_back(5'h00);
        hold(7'h40, 12);
        drain("glitch_pre_drain");
        hold(7'h79, 2);
        hold(7'h40, 20);
        drain("glitch_drain");

        out_ready = 1'b0;
        seg_n = 7'h19;
        wait_valid("rst_mid_valid");
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_valid", int'(out_valid), 0);
        check_eq("async_rst_err_count", int'(err_count), 0);
        seg_n = 7'h24;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("latency_edge%0d", k), int'(out_valid), (k == 7) ? 1 : 0);
        end
        exp_q.push_back(5'h02);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("rst_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
